// File: rtl/comparator_operand_driver.sv
// comparator_operand_driver: loads two bytes nibble-wise into an external comparator and captures its lt/eq/gt result
// Optional build macro RESULT_CHECK_EN adds an internal unsigned compare that flags disagreeing results on mismatch.
module comparator_operand_driver #(
  parameter int SETUP_CYC  = 2,
  parameter int PULSE_CYC  = 2,
  parameter int HOLD_CYC   = 1,
  parameter int SETTLE_CYC = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [7:0] a_in,
  input  logic [7:0] b_in,
  output logic [3:0] y,
  output logic       pb1,
  output logic       pb2,
  output logic       pb3,
  output logic       pb4,
  input  logic       lout,
  input  logic       gout,
  input  logic       eout,
  output logic       res_lt,
  output logic       res_eq,
  output logic       res_gt,
  output logic       done,
  output logic       busy,
  output logic       err_onehot,
  output logic       mismatch
);
  typedef enum logic [2:0] {IDLE, SETUP, PULSE, HOLD, SETTLE, CAPTURE} state_t;
  localparam logic [7:0] SETUP_L  = 8'(SETUP_CYC - 1);
  localparam logic [7:0] PULSE_L  = 8'(PULSE_CYC - 1);
  localparam logic [7:0] HOLD_L   = 8'(HOLD_CYC - 1);
  localparam logic [7:0] SETTLE_L = 8'(SETTLE_CYC - 1);
  state_t state_q, state_d;
  logic [7:0] cnt_q, cnt_d, a_q, a_d, b_q, b_d;
  logic [1:0] idx_q, idx_d;
  logic [3:0] y_q, y_d, pb_q, pb_d, nib_d;
  logic       lt_q, lt_d, eq_q, eq_d, gt_q, gt_d, err_q, err_d, last, cap, phase_d;
  assign last     = cnt_q == 8'd0;
  assign cap      = state_q == SETTLE && last;
  assign in_ready = state_q == IDLE;
  assign busy     = ~in_ready;
  assign done     = state_q == CAPTURE;
  assign y        = y_q;
  assign {pb4, pb3, pb2, pb1} = pb_q;
  assign {res_lt, res_eq, res_gt, err_onehot} = {lt_q, eq_q, gt_q, err_q};
  // phase sequencing: each phase counts down its own length, nibble index advances after every HOLD
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q - 8'd1;
    idx_d   = idx_q;
    a_d     = a_q;
    b_d     = b_q;
    case (state_q)
      IDLE:    if (in_valid) begin
        state_d = SETUP;
        cnt_d   = SETUP_L;
        idx_d   = 2'd0;
        a_d     = a_in;
        b_d     = b_in;
      end
      SETUP:   if (last) begin
        state_d = PULSE;
        cnt_d   = PULSE_L;
      end
      PULSE:   if (last) begin
        state_d = HOLD;
        cnt_d   = HOLD_L;
      end
      HOLD:    if (last) begin
        state_d = idx_q == 2'd3 ? SETTLE : SETUP;
        cnt_d   = idx_q == 2'd3 ? SETTLE_L : SETUP_L;
        idx_d   = idx_q + 2'd1;
      end
      SETTLE:  if (last) state_d = CAPTURE;
      default: state_d = IDLE;
    endcase
    phase_d = state_d inside {SETUP, PULSE, HOLD};
    nib_d   = idx_d[1] ? (idx_d[0] ? b_d[7:4] : b_d[3:0]) : (idx_d[0] ? a_d[7:4] : a_d[3:0]);
    y_d     = phase_d ? nib_d : 4'h0;
    pb_d    = state_d == PULSE ? 4'b0001 << idx_d : 4'b0000;
    {lt_d, eq_d, gt_d} = cap ? {lout, eout, gout} : {lt_q, eq_q, gt_q};
    err_d   = cap ? !$onehot({lout, eout, gout}) : err_q;
  end
  // all state and every comparator-facing output come straight from these flops
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= 8'd0;
      idx_q   <= 2'd0;
      a_q     <= 8'd0;
      b_q     <= 8'd0;
      y_q     <= 4'h0;
      pb_q    <= 4'h0;
      {lt_q, eq_q, gt_q, err_q} <= 4'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      a_q     <= a_d;
      b_q     <= b_d;
      y_q     <= y_d;
      pb_q    <= pb_d;
      {lt_q, eq_q, gt_q, err_q} <= {lt_d, eq_d, gt_d, err_d};
    end
  end
`ifdef RESULT_CHECK_EN
  logic mm_q, mm_d;
  assign mm_d     = cap ? ({lout, eout, gout} != {a_q < b_q, a_q == b_q, a_q > b_q}) : mm_q;
  assign mismatch = mm_q;
  // result cross-check against the registered operands, updated only at capture
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) mm_q <= 1'b0;
    else        mm_q <= mm_d;
  end
`else
  assign mismatch = 1'b0;
`endif
endmodule

// File: doc/comparator_operand_driver.md
COMPARATOR_OPERAND_DRIVER -- requirements
Module: comparator_operand_driver

Interface
REQ-001 Parameter SETUP_CYC, default 2: cycles y is stable before a pb rising edge (legal 1..15).
REQ-002 Parameter PULSE_CYC, default 2: cycles each pb is held high (legal 1..15).
REQ-003 Parameter HOLD_CYC, default 1: cycles y is held after pb falls (legal 1..15).
REQ-004 Parameter SETTLE_CYC, default 4: cycles from the last pb fall to result sampling (legal 1..255).
REQ-005 Ports SHALL be, clock and reset first:
- clk  in  1  single system clock; all state on its rising edge
- rst_n  in  1  asynchronous, active-low reset
- in_valid  in  1  operand pair offered
- in_ready  out  1  block can accept a pair
- a_in  in  8  operand A
- b_in  in  8  operand B
- y  out  4  nibble bus to the comparator
- pb1, pb2, pb3, pb4  out  1 each  load strobes: A[3:0], A[7:4], B[3:0], B[7:4]
- lout, gout, eout  in  1 each  comparator result lines
- res_lt, res_eq, res_gt  out  1 each  captured result
- done  out  1  one-cycle pulse, result valid
- busy  out  1  transaction in progress
- err_onehot  out  1  captured triple was not one-hot
- mismatch  out  1  captured result differs from the internal expected result (see REQ-019)

Function
REQ-006 A transfer SHALL occur on a rising clk edge with in_valid=1 and in_ready=1; a_in and b_in are registered at that edge.
REQ-007 in_ready SHALL be 1 only in IDLE; busy SHALL equal the inverse of in_ready.
REQ-008 FSM states SHALL be IDLE -> SETUP -> PULSE -> HOLD, repeated for nibble index 0..3 in the order pb1, pb2, pb3, pb4, then SETTLE -> CAPTURE -> IDLE.
REQ-009 In SETUP, PULSE and HOLD, y SHALL equal the current nibble: A[3:0], A[7:4], B[3:0], B[7:4] for index 0..3.
REQ-010 Each phase SHALL last exactly its parameter count in cycles; only the pb of the current index SHALL be high, and only in PULSE.
REQ-011 All pb and y outputs SHALL be driven directly from flops, so they are glitch-free; at most one pb SHALL be high at any time.
REQ-012 lout, gout and eout SHALL be sampled on the last SETTLE edge into res_lt, res_gt and res_eq; the res outputs hold until the next capture.
REQ-013 done SHALL be high in CAPTURE for exactly one cycle, 4*(SETUP_CYC+PULSE_CYC+HOLD_CYC)+SETTLE_CYC+1 cycles after the accept edge (25 at defaults).
REQ-014 err_onehot SHALL be updated at each capture: 1 when the sampled triple has zero or more than one bit set, else 0.
REQ-015 A new transfer SHALL be accepted in the cycle after CAPTURE, which makes back-to-back transfers possible; in_valid outside IDLE SHALL be ignored.
REQ-016 Outside SETUP, PULSE and HOLD, y SHALL be 4'h0.

Reset
REQ-017 When rst_n=0, the block SHALL immediately go to IDLE, with y=0, all pb=0, res_*=0, done=0, busy=0, err_onehot=0, mismatch=0 and the internal operands cleared; in_ready SHALL be 1 after reset is released.
REQ-018 A reset in the middle of a transaction SHALL drop any high pb asynchronously; the partially loaded transaction is abandoned and no done is issued.

Configuration
REQ-019 Macro RESULT_CHECK_EN:
- Defined: at capture the block computes the expected lt/eq/gt from the registered A and B as unsigned values, and mismatch is set to 1 if the sampled triple differs from it, else 0.
- Undefined: no compare logic is built and mismatch is tied to 0.
- The mismatch port exists in both cases.

Verification
REQ-020 Apply A=8'h3C, B=8'hA5 with a model comparator -> y sequence C,3,5,A on pb1..pb4; res_lt=1, res_eq=0, res_gt=0; done exactly 25 cycles after accept.
REQ-021 Apply A=8'h7E, B=8'h7E -> res_eq=1, err_onehot=0; then A=8'hFF, B=8'h00 back-to-back (in_valid held) -> res_gt=1, with exactly one idle-ready cycle between the two transactions.
REQ-022 Pull rst_n low during the PULSE of pb3 -> pb3 falls the same cycle; no done; in_ready=1 after release; the next transfer completes normally.
REQ-023 Force lout=1 and gout=1 at sampling -> err_onehot=1; drive a valid triple on the next transaction -> err_onehot clears to 0.
REQ-024 With RESULT_CHECK_EN defined, A=8'h10, B=8'h01, comparator forced to report lt -> mismatch=1; without the macro -> mismatch=0.
REQ-025 Run with SETUP_CYC=1, PULSE_CYC=1, HOLD_CYC=1, SETTLE_CYC=1 -> done 14 cycles after accept; y is stable during every pb-high cycle.
